// File: rtl/fir_cmem_rx.sv
// Double-buffered FP16 FIR coefficient memory: a shadow bank loads while the active bank
// serves the MAC sequencer, and banks swap on the first frame-marker rise after a full load.
module fir_cmem_rx #(
  parameter int AW  = 6,
  parameter int DW  = 16,
  parameter bit FTZ = 1'b1
) (
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic          clk_slow,
  input  logic          cload,
  input  logic [AW-1:0] caddr,
  input  logic [DW-1:0] cin,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          coef_valid,
  output logic          swap,
  output logic [1:0]    state,
  output logic [6:0]    denorm_cnt,
  output logic          ovw_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [DW-1:0]    bank0 [DEPTH];
  logic [DW-1:0]    bank1 [DEPTH];
  logic             bank_sel;
  logic [DEPTH-1:0] mask;
  logic [DEPTH-1:0] wr_bit;
  logic             s_q;
  logic             slow_rise;
  logic             mask_full;
  logic             commit;
  logic             is_sub;
  logic [DW-1:0]    wdata;

  assign slow_rise = clk_slow & ~s_q;
  assign commit    = (fsm_q == READY) && slow_rise;
  assign mask_full = &(mask | wr_bit);
  assign is_sub    = (cin[14:10] == 5'd0) && (cin[9:0] != 10'd0);
  assign wdata     = (FTZ && is_sub) ? {cin[DW-1], {(DW-1){1'b0}}} : cin;
  assign state     = fsm_q;

  always_comb begin
    wr_bit         = '0;
    wr_bit[caddr]  = cload;
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (cload) fsm_d = LOADING;
      LOADING: if (cload && mask_full) fsm_d = READY;
      READY:   if (slow_rise) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Shadow bank is the one not selected; a write on the commit edge lands in the bank going live.
  always_ff @(posedge clk_fast) begin
    if (cload && rst_n) begin
      if (bank_sel) bank0[caddr] <= wdata;
      else          bank1[caddr] <= wdata;
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 1'b1;
      bank_sel   <= 1'b0;
      mask       <= '0;
      swap       <= 1'b0;
      coef_valid <= 1'b0;
      denorm_cnt <= 7'd0;
      ovw_err    <= 1'b0;
    end else begin
      s_q  <= clk_slow;
      swap <= commit;
      if (commit) begin
        bank_sel   <= ~bank_sel;
        coef_valid <= 1'b1;
        mask       <= '0;
      end else if (cload) begin
        mask <= mask | wr_bit;
      end
      if (cload && (fsm_q == LOADING) && mask[caddr]) ovw_err <= 1'b1;
      if (cload) begin
        if (fsm_q == IDLE)                      denorm_cnt <= {6'd0, is_sub};
        else if (is_sub && denorm_cnt != 7'd127) denorm_cnt <= denorm_cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n)          rd_data <= '0;
    else if (!coef_valid) rd_data <= '0;
    else if (bank_sel)   rd_data <= bank1[rd_addr];
    else                 rd_data <= bank0[rd_addr];
  end

endmodule

// File: tb/tb_fir_cmem_rx.sv
// Directed bench for fir_cmem_rx; readback expectations go through a scoreboard queue.
module tb_fir_cmem_rx;

  logic        clk_fast = 1'b0;
  logic        rst_n;
  logic        clk_slow;
  logic        cload;
  logic [5:0]  caddr;
  logic [15:0] cin;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        coef_valid;
  logic        swap;
  logic [1:0]  state;
  logic [6:0]  denorm_cnt;
  logic        ovw_err;

  int n_assert = 0;
  int n_fail   = 0;
  int swap_seen = 0;
  int swap_base;
  logic [15:0] sb_q [$];

  fir_cmem_rx #(.AW(6), .DW(16), .FTZ(1'b1)) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .cload(cload),
    .caddr(caddr), .cin(cin), .rd_addr(rd_addr), .rd_data(rd_data),
    .coef_valid(coef_valid), .swap(swap), .state(state),
    .denorm_cnt(denorm_cnt), .ovw_err(ovw_err)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
    if (swap) swap_seen++;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic slow);
    cload = 1'b1; caddr = a; cin = d; clk_slow = slow;
    tick();
    cload = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
    logic [15:0] e;
    sb_q.push_back(exp);
    rd_addr = a;
    tick();
    e = sb_q.pop_front();
    chk(tag, rd_data, e);
  endtask

  initial begin
    rst_n = 1'b0; clk_slow = 1'b0; cload = 1'b0; caddr = '0; cin = '0; rd_addr = '0;
    repeat (2) @(posedge clk_fast);
    #1;
    chk("rst_state", {14'd0, state}, 16'd0);
    chk("rst_valid", {15'd0, coef_valid}, 16'd0);
    chk("rst_swap",  {15'd0, swap}, 16'd0);
    chk("rst_dn",    {9'd0, denorm_cnt}, 16'd0);
    chk("rst_ovw",   {15'd0, ovw_err}, 16'd0);
    chk("rst_rd",    rd_data, 16'h0000);
    rst_n = 1'b1;

    // frame marker toggling in IDLE must not swap
    for (int i = 0; i < 4; i++) begin clk_slow = i[0]; tick(); end
    clk_slow = 1'b0; tick();
    chk("idle_noswap", swap_seen[15:0], 16'd0);
    chk("idle_state", {14'd0, state}, 16'd0);

    // load 1: ramp values, marker toggling during the load
    for (int i = 0; i < 64; i++) begin
      wr(i[5:0], 16'h3C00 + i[15:0], (i % 4) == 1);
      if (i == 62) chk("load1_loading", {14'd0, state}, 16'd1);
    end
    chk("load1_ready", {14'd0, state}, 16'd2);
    chk("load1_noswap", swap_seen[15:0], 16'd0);
    chk("load1_invalid", {15'd0, coef_valid}, 16'd0);
    rd("pre_commit_rd", 6'd5, 16'h0000);
    clk_slow = 1'b1; tick();
    chk("commit1_swap", {15'd0, swap}, 16'd1);
    chk("commit1_state", {14'd0, state}, 16'd0);
    chk("commit1_valid", {15'd0, coef_valid}, 16'd1);
    clk_slow = 1'b0; tick();
    chk("swap_one_cycle", {15'd0, swap}, 16'd0);
    rd("rd_a5", 6'd5, 16'h3C05);
    rd("rd_a63", 6'd63, 16'h3C3F);

    // load 2: 65th write restarts loading; subnormals flushed and counted
    wr(6'd0, 16'h4000, 1'b0);
    chk("wrap_loading", {14'd0, state}, 16'd1);
    rd("active_unchanged", 6'd0, 16'h3C00);
    for (int i = 1; i < 64; i++)
      wr(i[5:0], (i == 3) ? 16'h0001 : (i == 7) ? 16'h8200 : 16'h1000 + i[15:0], 1'b0);
    chk("denorm_cnt2", {9'd0, denorm_cnt}, 16'd2);
    chk("load2_ready", {14'd0, state}, 16'd2);
    wr(6'd10, 16'h5555, 1'b0);
    chk("ready_wr_state", {14'd0, state}, 16'd2);
    chk("ready_wr_noovw", {15'd0, ovw_err}, 16'd0);
    wr(6'd11, 16'h6666, 1'b1);
    chk("commit2_swap", {15'd0, swap}, 16'd1);
    clk_slow = 1'b0;
    rd("rd2_a0", 6'd0, 16'h4000);
    rd("flush_pos", 6'd3, 16'h0000);
    rd("flush_neg", 6'd7, 16'h8000);
    rd("ready_overwrite", 6'd10, 16'h5555);
    rd("commit_edge_wr", 6'd11, 16'h6666);
    rd("rd2_a5", 6'd5, 16'h1005);

    // load 3: counter cleared, rewrite flagged, late marker rises ignored until READY
    swap_base = swap_seen;
    wr(6'd0, 16'h2000, 1'b0);
    chk("denorm_clear", {9'd0, denorm_cnt}, 16'd0);
    for (int i = 1; i < 64; i++) begin
      wr(i[5:0], 16'h2000 + i[15:0], (i == 20) || (i == 63));
      if (i == 10) begin
        wr(6'd10, 16'hBBBB, 1'b0);
        chk("ovw_set", {15'd0, ovw_err}, 16'd1);
      end
    end
    chk("full_and_rise_ready", {14'd0, state}, 16'd2);
    chk("load3_noswap", 16'(swap_seen - swap_base), 16'd0);
    clk_slow = 1'b0; tick();
    clk_slow = 1'b1; tick();
    chk("commit3_swap", {15'd0, swap}, 16'd1);
    clk_slow = 1'b0;
    rd("ovw_data", 6'd10, 16'hBBBB);
    rd("rd3_a9", 6'd9, 16'h2009);
    chk("ovw_sticky", {15'd0, ovw_err}, 16'd1);

    // reset mid-load at write 30
    for (int i = 0; i < 30; i++) wr(i[5:0], 16'h3000 + i[15:0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_state", {14'd0, state}, 16'd0);
    chk("mrst_valid", {15'd0, coef_valid}, 16'd0);
    chk("mrst_ovw", {15'd0, ovw_err}, 16'd0);
    chk("mrst_dn", {9'd0, denorm_cnt}, 16'd0);
    chk("mrst_rd", rd_data, 16'h0000);
    chk("mrst_swap", {15'd0, swap}, 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr(i[5:0], 16'h0700 + i[15:0], 1'b0);
      if (i == 62) chk("post_rst_loading", {14'd0, state}, 16'd1);
    end
    chk("post_rst_ready", {14'd0, state}, 16'd2);
    rd("post_rst_invalid", 6'd5, 16'h0000);
    clk_slow = 1'b1; tick();
    chk("post_rst_swap", {15'd0, swap}, 16'd1);
    clk_slow = 1'b0;
    rd("post_rst_a5", 6'd5, 16'h0705);
    rd("post_rst_a40", 6'd40, 16'h0728);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
